// File: rtl/dfh_chain_walker.sv
// dfh_chain_walker
//   Walks a Device Feature Header chain over a 64-bit CSR read port. Starting
//   at start_addr it reads one DFH at a time, captures each header's ID, major
//   version, type and absolute address into a small table, and follows the
//   24-bit next-offset field until end-of-list or a fault.
//
// Ports
//   clk, rst               clock, asynchronous active-high reset
//   start, start_addr      walk launch pulse and first DFH byte address
//   busy, done             walk in progress / one-cycle end-of-walk pulse
//   err, err_code          fault flag and code of the last walk
//                          (1 timeout, 2 rsp_err, 3 overflow, 4 wrap, 5 misaligned)
//   feat_count             headers captured in the last walk
//   rd_req_*               read request channel (valid/ready, address)
//   rd_rsp_*               read response channel (valid, data, error)
//   q_idx, q_*             registered table query port, one-cycle latency
module dfh_chain_walker #(
    parameter int ADDR_W      = 20,
    parameter int MAX_FEAT    = 32,
    parameter int TIMEOUT_CYC = 1024,
    parameter int IDX_W       = $clog2(MAX_FEAT)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [2:0]        err_code,
    output logic [IDX_W:0]    feat_count,
    output logic              rd_req_valid,
    input  logic              rd_req_ready,
    output logic [ADDR_W-1:0] rd_req_addr,
    input  logic              rd_rsp_valid,
    input  logic [63:0]       rd_rsp_data,
    input  logic              rd_rsp_err,
    input  logic [IDX_W-1:0]  q_idx,
    output logic [11:0]       q_feat_id,
    output logic [3:0]        q_major,
    output logic [3:0]        q_feat_type,
    output logic [ADDR_W-1:0] q_addr
);

    localparam int             CNT_W     = $clog2(TIMEOUT_CYC);
    // The counter is compared before its increment, so matching TIMEOUT_CYC-2
    // is the edge on which it reaches TIMEOUT_CYC-1.
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYC - 2);
    localparam logic [IDX_W:0] FEAT_FULL = (IDX_W + 1)'(MAX_FEAT);
    localparam int             ENT_W     = 20 + ADDR_W;

    localparam logic [2:0] E_NONE    = 3'd0;
    localparam logic [2:0] E_TIMEOUT = 3'd1;
    localparam logic [2:0] E_RSP     = 3'd2;
    localparam logic [2:0] E_OVFL    = 3'd3;
    localparam logic [2:0] E_WRAP    = 3'd4;
    localparam logic [2:0] E_ALIGN   = 3'd5;

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_EVAL, S_FIN} state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [2:0]          w_fin_code;
    logic                w_tab_we;

    logic [ADDR_W-1:0]   r_cur_addr;
    logic [CNT_W-1:0]    r_to_cnt;
    logic                r_busy;
    logic                r_done;
    logic                r_err;
    logic [2:0]          r_err_code;
    logic [IDX_W:0]      r_feat_count;

    logic [11:0]         r_hdr_id;
    logic [3:0]          r_hdr_major;
    logic [3:0]          r_hdr_type;
    logic                r_hdr_eol;
    logic [23:0]         r_hdr_off;
    logic                r_hdr_err;

    logic [ENT_W-1:0]    r_tab [MAX_FEAT];
    logic [ENT_W-1:0]    r_q_ent;

    logic [ADDR_W+23:0]  w_sum;
    logic                w_wrap;
    logic [IDX_W:0]      w_cnt_inc;
    logic                w_unused;

    // Next address at full width so a carry past the BAR window is visible.
    assign w_sum     = {24'd0, r_cur_addr} + {{ADDR_W{1'b0}}, r_hdr_off};
    assign w_wrap    = |w_sum[ADDR_W+23:ADDR_W];
    assign w_cnt_inc = r_feat_count + (IDX_W + 1)'(1);
    // Minor version and reserved bits are not tracked.
    assign w_unused  = ^rd_rsp_data[59:41];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_fin_code  = E_NONE;
        w_tab_we    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (|start_addr[2:0]) begin
                        w_state_nxt = S_FIN;
                        w_fin_code  = E_ALIGN;
                    end else begin
                        w_state_nxt = S_REQ;
                    end
                end
            end
            S_REQ: begin
                if (rd_req_ready) w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                // A response in the final timeout cycle still wins.
                if (rd_rsp_valid) begin
                    w_state_nxt = S_EVAL;
                end else if (r_to_cnt == TO_LAST) begin
                    w_state_nxt = S_FIN;
                    w_fin_code  = E_TIMEOUT;
                end
            end
            S_EVAL: begin
                w_state_nxt = S_FIN;
                if (r_hdr_err) begin
                    w_fin_code = E_RSP;
                end else begin
                    // The header itself is valid, so it is stored even if
                    // its link turns out to be faulty.
                    w_tab_we = 1'b1;
                    if (r_hdr_eol || (r_hdr_off == 24'd0)) w_fin_code = E_NONE;
                    else if (|r_hdr_off[2:0])              w_fin_code = E_ALIGN;
                    else if (w_wrap)                       w_fin_code = E_WRAP;
                    else if (w_cnt_inc == FEAT_FULL)       w_fin_code = E_OVFL;
                    else                                   w_state_nxt = S_REQ;
                end
            end
            S_FIN: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cur_addr   <= '0;
            r_to_cnt     <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_err_code   <= E_NONE;
            r_feat_count <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_cur_addr   <= start_addr;
                        r_err        <= 1'b0;
                        r_err_code   <= w_fin_code;
                        r_feat_count <= '0;
                        r_busy       <= 1'b1;
                    end
                end
                S_REQ: begin
                    if (rd_req_ready) r_to_cnt <= '0;
                end
                S_WAIT: begin
                    r_to_cnt   <= r_to_cnt + CNT_W'(1);
                    r_err_code <= w_fin_code;
                end
                S_EVAL: begin
                    if (w_tab_we)               r_feat_count <= w_cnt_inc;
                    if (w_state_nxt == S_REQ)   r_cur_addr   <= w_sum[ADDR_W-1:0];
                    r_err_code <= w_fin_code;
                end
                S_FIN: begin
                    r_done <= 1'b1;
                    r_busy <= 1'b0;
                    r_err  <= (r_err_code != E_NONE);
                end
                default: begin
                end
            endcase
        end
    end

    // Response capture and feature table: data only, no reset.
    always_ff @(posedge clk) begin
        if ((r_state == S_WAIT) && rd_rsp_valid) begin
            r_hdr_id    <= rd_rsp_data[11:0];
            r_hdr_major <= rd_rsp_data[15:12];
            r_hdr_off   <= rd_rsp_data[39:16];
            r_hdr_eol   <= rd_rsp_data[40];
            r_hdr_type  <= rd_rsp_data[63:60];
            r_hdr_err   <= rd_rsp_err;
        end
        if (w_tab_we) begin
            r_tab[r_feat_count[IDX_W-1:0]] <= {r_hdr_id, r_hdr_major, r_hdr_type, r_cur_addr};
        end
    end

    // Query read: a same-cycle write to the same index returns the old entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_q_ent <= '0;
        else     r_q_ent <= r_tab[q_idx];
    end

    assign busy         = r_busy;
    assign done         = r_done;
    assign err          = r_err;
    assign err_code     = r_err_code;
    assign feat_count   = r_feat_count;
    assign rd_req_valid = (r_state == S_REQ);
    assign rd_req_addr  = r_cur_addr;
    assign q_feat_id    = r_q_ent[ENT_W-1 -: 12];
    assign q_major      = r_q_ent[ENT_W-13 -: 4];
    assign q_feat_type  = r_q_ent[ENT_W-17 -: 4];
    assign q_addr       = r_q_ent[ADDR_W-1:0];

endmodule

// File: tb/tb_dfh_chain_walker.sv
module tb_dfh_chain_walker;

    localparam int AW = 20;
    localparam int MF = 4;
    localparam int TO = 16;
    localparam int IW = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] start_addr = '0;
    logic          busy, done, err;
    logic [2:0]    err_code;
    logic [IW:0]   feat_count;
    logic          rd_req_valid;
    logic          rd_req_ready = 1'b0;
    logic [AW-1:0] rd_req_addr;
    logic          rd_rsp_valid = 1'b0;
    logic [63:0]   rd_rsp_data = '0;
    logic          rd_rsp_err = 1'b0;
    logic [IW-1:0] q_idx = '0;
    logic [11:0]   q_feat_id;
    logic [3:0]    q_major, q_feat_type;
    logic [AW-1:0] q_addr;

    dfh_chain_walker #(.ADDR_W(AW), .MAX_FEAT(MF), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst), .start(start), .start_addr(start_addr),
        .busy(busy), .done(done), .err(err), .err_code(err_code),
        .feat_count(feat_count), .rd_req_valid(rd_req_valid),
        .rd_req_ready(rd_req_ready), .rd_req_addr(rd_req_addr),
        .rd_rsp_valid(rd_rsp_valid), .rd_rsp_data(rd_rsp_data),
        .rd_rsp_err(rd_rsp_err), .q_idx(q_idx), .q_feat_id(q_feat_id),
        .q_major(q_major), .q_feat_type(q_feat_type), .q_addr(q_addr)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Fabric memory and behaviour controls
    logic [63:0]   mem [int];
    int            drop_n = 0;     // 1-based read number that never gets a response
    int            err_n  = 0;     // 1-based read number answered with rd_rsp_err
    int            stale_n = 0;    // cycles of spurious response valid
    int            hold_n = 0;     // cycles of forced ready low
    bit            rand_rdy = 0;
    int            lat_tab [8];
    logic [AW-1:0] obs_reads [$];
    time           acc_time [$];

    function automatic logic [63:0] rd_mem(input longint a);
        if (mem.exists(int'(a))) return mem[int'(a)];
        return 64'h0000_0100_0000_0000;   // unmapped: empty header with eol
    endfunction

    function automatic logic [63:0] mk_hdr(input logic [3:0] ty, input logic [3:0] mn,
                                           input bit eol, input logic [23:0] off,
                                           input logic [3:0] mj, input logic [11:0] id);
        return {ty, 8'hA5, mn, 7'h35, eol, off, mj, id};
    endfunction

    // Fabric responder: one outstanding read, per-read latency from lat_tab.
    bit            fb_pend = 0;
    longint        fb_addr = 0;
    int            fb_lat = 0;
    bit            fb_err = 0;
    bit            fb_pv = 0;
    bit            fb_pr = 0;
    logic [AW-1:0] fb_pa = '0;

    initial begin
        forever begin
            @(negedge clk);
            rd_rsp_valid = 1'b0;
            rd_rsp_err   = 1'b0;
            rd_rsp_data  = {$urandom, $urandom};
            if (rst) begin
                fb_pend = 0; fb_pv = 0; fb_pr = 0;
                rd_req_ready = 1'b0;
            end else begin
                if (fb_pv && fb_pr) begin
                    obs_reads.push_back(fb_pa);
                    acc_time.push_back($time);
                    if (obs_reads.size() != drop_n) begin
                        fb_pend = 1;
                        fb_addr = longint'(fb_pa);
                        fb_lat  = (obs_reads.size() <= 8) ? lat_tab[obs_reads.size()-1] : 0;
                        fb_err  = (obs_reads.size() == err_n);
                    end
                end
                if (fb_pend) begin
                    if (fb_lat == 0) begin
                        rd_rsp_valid = 1'b1;
                        rd_rsp_data  = rd_mem(fb_addr);
                        rd_rsp_err   = fb_err;
                        fb_pend      = 0;
                    end else begin
                        fb_lat--;
                    end
                end else if (stale_n > 0) begin
                    rd_rsp_valid = 1'b1;
                    rd_rsp_err   = 1'b1;
                end
                if (stale_n > 0) stale_n--;
                if (hold_n > 0) begin
                    rd_req_ready = 1'b0;
                    hold_n--;
                end else begin
                    rd_req_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
                end
                fb_pv = rd_req_valid;
                fb_pa = rd_req_addr;
                fb_pr = rd_req_ready;
            end
        end
    end

    // Reference model: follow the chain in memory with plain arithmetic.
    int            e_code;
    longint        e_reads [$];
    logic [39:0]   e_tab [$];      // {id, major, type, addr}

    task automatic model_walk(input logic [AW-1:0] sa);
        longint a;
        longint off;
        logic [63:0] h;
        int n;
        e_reads.delete();
        e_tab.delete();
        e_code = 0;
        if (sa % 8 != 0) begin
            e_code = 5;
            return;
        end
        a = longint'(sa);
        forever begin
            e_reads.push_back(a);
            n = e_reads.size();
            if (n == drop_n || (n <= 8 && lat_tab[n-1] >= TO - 1)) begin e_code = 1; return; end
            if (n == err_n) begin e_code = 2; return; end
            h = rd_mem(a);
            e_tab.push_back({h[11:0], h[15:12], h[63:60], a[AW-1:0]});
            off = longint'(h[39:16]);
            if (h[40] || off == 0)       return;
            if (off % 8 != 0)            begin e_code = 5; return; end
            if (a + off >= (64'd1 << AW)) begin e_code = 4; return; end
            if (e_tab.size() == MF)      begin e_code = 3; return; end
            a = a + off;
        end
    endtask

    task automatic clr_cfg();
        mem.delete();
        drop_n = 0; err_n = 0; stale_n = 0; hold_n = 0; rand_rdy = 0;
        for (int i = 0; i < 8; i++) lat_tab[i] = 0;
    endtask

    int  done_k;
    time done_t;

    task automatic run_walk(input string pfx, input logic [AW-1:0] sa);
        bit got;
        int k;
        model_walk(sa);
        obs_reads.delete();
        acc_time.delete();
        @(negedge clk);
        start = 1'b1;
        start_addr = sa;
        got = 0;
        done_k = 0;
        for (k = 1; k <= 600; k++) begin
            @(negedge clk);
            if (k == 1) begin
                start = 1'b0;
                chk({pfx, "_busy"}, 64'(busy), 64'(1));
            end
            if (done) begin
                got = 1;
                done_k = k;
                break;
            end
        end
        done_t = $time;
        chk({pfx, "_done_seen"}, 64'(got), 64'(1));
        chk({pfx, "_code"}, 64'(err_code), 64'(e_code));
        chk({pfx, "_err"}, 64'(err), 64'(e_code != 0));
        chk({pfx, "_count"}, 64'(feat_count), 64'(e_tab.size()));
        chk({pfx, "_busy_end"}, 64'(busy), 64'(0));
        chk({pfx, "_nreads"}, 64'(obs_reads.size()), 64'(e_reads.size()));
        for (int i = 0; i < e_reads.size() && i < obs_reads.size(); i++)
            chk({pfx, "_rd_addr"}, 64'(obs_reads[i]), 64'(e_reads[i]));
        @(negedge clk);
        chk({pfx, "_done_pulse"}, 64'(done), 64'(0));
        for (int i = 0; i < e_tab.size(); i++) begin
            q_idx = IW'(i);
            @(negedge clk);
            chk({pfx, "_q_id"},   64'(q_feat_id),   64'(e_tab[i][39:28]));
            chk({pfx, "_q_maj"},  64'(q_major),     64'(e_tab[i][27:24]));
            chk({pfx, "_q_type"}, 64'(q_feat_type), 64'(e_tab[i][23:20]));
            chk({pfx, "_q_addr"}, 64'(q_addr),      64'(e_tab[i][19:0]));
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic chk_reset_outputs(input string pfx);
        chk({pfx, "_valid"}, 64'(rd_req_valid), 64'(0));
        chk({pfx, "_busy"},  64'(busy),         64'(0));
        chk({pfx, "_done"},  64'(done),         64'(0));
        chk({pfx, "_err"},   64'(err),          64'(0));
        chk({pfx, "_code"},  64'(err_code),     64'(0));
        chk({pfx, "_count"}, 64'(feat_count),   64'(0));
        chk({pfx, "_addr"},  64'(rd_req_addr),  64'(0));
        chk({pfx, "_qid"},   64'(q_feat_id),    64'(0));
        chk({pfx, "_qaddr"}, 64'(q_addr),       64'(0));
    endtask

    // Global watchdog
    initial begin
        #900000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        longint a;
        logic [AW-1:0] sa;
        logic [23:0] off;
        bit eol;
        int len, sel;

        #1 rst = 1'b1;
        #3;
        chk_reset_outputs("init");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Three-header chain, zero-latency fabric
        clr_cfg();
        mem[32'h0000] = mk_hdr(4'h3, 4'h1, 1'b0, 24'h001000, 4'h2, 12'h000);
        mem[32'h1000] = mk_hdr(4'h3, 4'h0, 1'b0, 24'h002000, 4'h1, 12'h001);
        mem[32'h3000] = mk_hdr(4'h4, 4'h2, 1'b1, 24'h000000, 4'h5, 12'h004);
        run_walk("chain3", 20'h0);

        // Second read never answered: timeout exactly TO cycles after accept
        drop_n = 2;
        run_walk("tmo", 20'h0);
        if (acc_time.size() >= 2) chk("tmo_latency", 64'(done_t - acc_time[1]), 64'(TO * 10));
        else                      chk("tmo_accepts", 64'(acc_time.size()), 64'(2));
        drop_n = 0;

        // Second response flagged as error
        err_n = 2;
        run_walk("rsperr", 20'h0);
        err_n = 0;

        // Response in the final timeout cycle wins; one cycle later loses
        lat_tab[1] = TO - 2;
        run_walk("race_ok", 20'h0);
        lat_tab[1] = TO - 1;
        run_walk("race_late", 20'h0);
        lat_tab[1] = 0;

        // Chain longer than the table: overflow after MF headers
        clr_cfg();
        for (int k = 0; k < 8; k++)
            mem[32'h100 + 8 * k] = mk_hdr(4'h1, 4'h0, 1'b0, 24'h000008, 4'h0, 12'(k + 16));
        run_walk("ovfl", 20'h100);

        // Address wrap past the window
        clr_cfg();
        mem[32'hFF000] = mk_hdr(4'h2, 4'h0, 1'b0, 24'h002000, 4'h3, 12'h0AB);
        run_walk("wrap", 20'hFF000);

        // Misaligned next offset
        mem[32'hFF000] = mk_hdr(4'h2, 4'h0, 1'b0, 24'h001004, 4'h3, 12'h0CD);
        run_walk("misoff", 20'hFF000);

        // Misaligned start: no read, done two cycles after start
        run_walk("misstart", 20'h00004);
        chk("misstart_latency", 64'(done_k), 64'(2));

        // Asynchronous reset while a request is stalled
        clr_cfg();
        mem[32'h2000] = mk_hdr(4'h5, 4'h0, 1'b0, 24'h000400, 4'h6, 12'h222);
        mem[32'h2400] = mk_hdr(4'h6, 4'h0, 1'b1, 24'h000000, 4'h7, 12'h333);
        q_idx = '0;
        hold_n = 1000;
        @(negedge clk);
        start = 1'b1;
        start_addr = 20'h2000;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_pre_valid", 64'(rd_req_valid), 64'(1));
        #2 rst = 1'b1;
        #1;
        chk_reset_outputs("midrst");
        @(negedge clk);
        rst = 1'b0;
        #1;
        hold_n = 6;
        stale_n = 6;
        run_walk("post_rst", 20'h2000);

        // Randomized chains
        for (int t = 0; t < 25; t++) begin
            clr_cfg();
            rand_rdy = 1;
            for (int i = 0; i < 8; i++) lat_tab[i] = $urandom_range(0, 4);
            a = longint'($urandom_range(0, 32'h7FFF)) * 8;
            sa = a[AW-1:0];
            len = $urandom_range(1, 6);
            for (int k = 0; k < len; k++) begin
                sel = $urandom_range(0, 19);
                if (k == len - 1) begin
                    if (sel < 10) begin eol = 1; off = 24'($urandom); end
                    else          begin eol = 0; off = 24'h0; end
                end else begin
                    eol = 0;
                    off = 24'($urandom_range(1, 32'h800) * 8);
                    if (sel == 0) off = off | 24'($urandom_range(1, 7));
                    if (sel == 1) off = 24'hFC0000;
                end
                mem[int'(a)] = mk_hdr(4'($urandom), 4'($urandom), eol, off, 4'($urandom), 12'($urandom));
                if (eol || off == 24'h0 || off[2:0] != 3'd0 || off == 24'hFC0000) break;
                a = a + longint'(off);
            end
            sel = $urandom_range(0, 15);
            if (sel == 0) err_n = $urandom_range(1, 3);
            if (sel == 1) drop_n = $urandom_range(1, 3);
            if (sel == 2) sa[2] = 1'b1;
            if (sel == 3) lat_tab[$urandom_range(0, 3)] = $urandom_range(TO - 3, TO - 1);
            run_walk("rnd", sa);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
